sseg_scan_monitor: RTL and testbench

//  Receive-side decoder for the 4-digit multiplexed seven-segment bus (an/seg, both active-low).

---
 rtl/sseg_pkg.sv | 20 ++
 rtl/sseg_glyph_decode.sv | 22 ++
 rtl/sseg_scan_monitor.sv | 218 +++++++++++++++++++++
 tb/tb_sseg_scan_monitor.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment scan monitor.
// Glyphs are active-high {g,f,e,d,c,b,a}.
package sseg_pkg;

    localparam logic [6:0] GLYPHS [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [6:0] SQ_UPPER   = 7'h63;
    localparam logic [6:0] SQ_LOWER   = 7'h5C;
    localparam logic [3:0] ANODE_IDLE = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        LOCKED
    } state_t;

endpackage

// File: rtl/sseg_glyph_decode.sv
// Maps a 7-bit active-high glyph to its hex value; blank or unknown glyphs
// decode to 0 with valid low.
module sseg_glyph_decode
    import sseg_pkg::*;
(
    input  logic [6:0] segs,
    output logic       valid,
    output logic [3:0] hex
);

    always_comb begin
        valid = 1'b0;
        hex   = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (segs == GLYPHS[i]) begin
                valid = 1'b1;
                hex   = 4'(i);
            end
        end
    end

endmodule

// File: rtl/sseg_scan_monitor.sv
// Receive-side monitor for a 4-digit multiplexed seven-segment bus: filters,
// captures a per-digit frame, decodes hex glyphs and the rotating square.
module sseg_scan_monitor
    import sseg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned FRAME_TIMEOUT = 400_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an_in,
    input  logic [7:0]  seg_in,
    output logic [31:0] digit_seg_o,
    output logic [15:0] digit_hex_o,
    output logic [3:0]  hex_valid_o,
    output logic        frame_valid_o,
    output logic        frame_stb_o,
    output logic [2:0]  sq_pos_o,
    output logic        sq_valid_o,
    output logic        dir_cw_o,
    output logic        dir_valid_o,
    output logic        scan_err_o
);

    localparam int unsigned SW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int unsigned TW = (FRAME_TIMEOUT > 2) ? $clog2(FRAME_TIMEOUT) : 1;
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] STAB_PRE = SW'(STABLE_CYCLES - 2);
    localparam logic [TW-1:0] TO_MAX   = TW'(FRAME_TIMEOUT - 1);

    logic [3:0]    an_s1, an_s2, an_p;
    logic [7:0]    seg_s1, seg_s2, seg_p;
    logic [SW-1:0] stab_cnt;
    logic [TW-1:0] to_cnt;
    logic [3:0]    seen, seen_next, loaded;
    logic          changed, digit_act, illegal, capture, frame_done, timeout;
    logic          stb_next, drop;
    logic [1:0]    digit_idx;
    state_t        state, next_state;

    // Synchroniser and history reset to the idle line levels so that leaving
    // reset with a quiet bus does not look like an illegal anode pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_s1  <= ANODE_IDLE;
            an_s2  <= ANODE_IDLE;
            an_p   <= ANODE_IDLE;
            seg_s1 <= '1;
            seg_s2 <= '1;
            seg_p  <= '1;
        end else begin
            an_s1  <= an_in;
            an_s2  <= an_s1;
            an_p   <= an_s2;
            seg_s1 <= seg_in;
            seg_s2 <= seg_s1;
            seg_p  <= seg_s2;
        end
    end

    assign changed = {an_s2, seg_s2} != {an_p, seg_p};

    always_comb begin
        digit_act = 1'b0;
        digit_idx = '0;
        illegal   = 1'b0;
        case (an_s2)
            4'b1110:    begin digit_act = 1'b1; digit_idx = 2'd0; end
            4'b1101:    begin digit_act = 1'b1; digit_idx = 2'd1; end
            4'b1011:    begin digit_act = 1'b1; digit_idx = 2'd2; end
            4'b0111:    begin digit_act = 1'b1; digit_idx = 2'd3; end
            ANODE_IDLE: ;
            default:    illegal = 1'b1;
        endcase
    end

    // Capturing on the step into the saturated value gives one capture per dwell.
    assign capture    = digit_act && !changed && (stab_cnt == STAB_PRE);
    assign seen_next  = capture ? (seen | 4'(1 << digit_idx)) : seen;
    assign frame_done = (seen_next == 4'hF);
    assign timeout    = (state != IDLE) && !capture && (to_cnt == TO_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (capture) next_state = SCAN;
            SCAN:    if (timeout) next_state = IDLE;
                     else if (frame_done) next_state = LOCKED;
            LOCKED:  if (timeout) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        stb_next = (state != IDLE) && frame_done;
        drop     = timeout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt      <= '0;
            to_cnt        <= '0;
            seen          <= '0;
            loaded        <= '0;
            digit_seg_o   <= '0;
            frame_valid_o <= 1'b0;
            frame_stb_o   <= 1'b0;
            scan_err_o    <= 1'b0;
        end else begin
            if (changed || illegal)
                stab_cnt <= '0;
            else if (stab_cnt != STAB_MAX)
                stab_cnt <= stab_cnt + 1'b1;

            if (capture || state == IDLE)
                to_cnt <= '0;
            else if (to_cnt != TO_MAX)
                to_cnt <= to_cnt + 1'b1;

            if (drop || stb_next)
                seen <= '0;
            else
                seen <= seen_next;

            if (drop)
                loaded <= '0;
            else if (capture)
                loaded <= loaded | 4'(1 << digit_idx);

            for (int unsigned k = 0; k < 4; k++) begin
                if (capture && digit_idx == 2'(k))
                    digit_seg_o[8*k +: 8] <= ~seg_s2;
            end

            if (drop)
                frame_valid_o <= 1'b0;
            else if (stb_next)
                frame_valid_o <= 1'b1;

            frame_stb_o <= stb_next;
            scan_err_o  <= illegal && (an_s2 != an_p);
        end
    end

    logic [3:0] dec_valid;

    for (genvar g = 0; g < 4; g++) begin : g_dec
        sseg_glyph_decode u_dec (
            .segs  (digit_seg_o[8*g +: 7]),
            .valid (dec_valid[g]),
            .hex   (digit_hex_o[4*g +: 4])
        );
    end

    assign hex_valid_o = dec_valid & loaded;

    logic [3:0] nonblank;
    logic       sq_ok;
    logic [2:0] sq_new, pos_inc, pos_dec;

    always_comb begin
        sq_ok  = 1'b0;
        sq_new = '0;
        for (int unsigned k = 0; k < 4; k++)
            nonblank[k] = (digit_seg_o[8*k +: 7] != '0);
        for (int unsigned k = 0; k < 4; k++) begin
            if (nonblank == 4'(1 << k)) begin
                if (digit_seg_o[8*k +: 7] == SQ_UPPER) begin
                    sq_ok  = 1'b1;
                    sq_new = 3'(k);
                end else if (digit_seg_o[8*k +: 7] == SQ_LOWER) begin
                    sq_ok  = 1'b1;
                    sq_new = 3'(7 - k);
                end
            end
        end
    end

    assign pos_inc = sq_pos_o + 3'd1;
    assign pos_dec = sq_pos_o - 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_pos_o    <= '0;
            sq_valid_o  <= 1'b0;
            dir_cw_o    <= 1'b0;
            dir_valid_o <= 1'b0;
        end else if (drop) begin
            sq_valid_o  <= 1'b0;
            dir_valid_o <= 1'b0;
        end else if (frame_stb_o) begin
            sq_valid_o <= sq_ok;
            if (sq_ok)
                sq_pos_o <= sq_new;
            if (sq_ok && sq_valid_o) begin
                if (sq_new == pos_inc) begin
                    dir_cw_o    <= 1'b1;
                    dir_valid_o <= 1'b1;
                end else if (sq_new == pos_dec) begin
                    dir_cw_o    <= 1'b0;
                    dir_valid_o <= 1'b1;
                end else if (sq_new != sq_pos_o) begin
                    dir_valid_o <= 1'b0;
                end
            end else begin
                dir_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_monitor.sv
// Scoreboard bench: each scanned frame queues its expected decode, and a
// monitor checks the DUT whenever it emits frame_stb_o.
module tb_sseg_scan_monitor;
    import sseg_pkg::*;

    localparam int unsigned STABLE = 16;
    localparam int unsigned FTO    = 5000;
    localparam int          SQ_DW  = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  an_in = 4'hF;
    logic [7:0]  seg_in = 8'hFF;
    logic [31:0] digit_seg_o;
    logic [15:0] digit_hex_o;
    logic [3:0]  hex_valid_o;
    logic        frame_valid_o, frame_stb_o, sq_valid_o, dir_cw_o, dir_valid_o, scan_err_o;
    logic [2:0]  sq_pos_o;

    always #5 clk = ~clk;

    sseg_scan_monitor #(.STABLE_CYCLES(STABLE), .FRAME_TIMEOUT(FTO)) dut (
        .clk(clk), .rst_n(rst_n), .an_in(an_in), .seg_in(seg_in),
        .digit_seg_o(digit_seg_o), .digit_hex_o(digit_hex_o), .hex_valid_o(hex_valid_o),
        .frame_valid_o(frame_valid_o), .frame_stb_o(frame_stb_o), .sq_pos_o(sq_pos_o),
        .sq_valid_o(sq_valid_o), .dir_cw_o(dir_cw_o), .dir_valid_o(dir_valid_o),
        .scan_err_o(scan_err_o)
    );

    typedef struct {
        logic [15:0] hex;
        logic [3:0]  hv;
        logic        sqv;
        logic [2:0]  pos;
        logic        dv;
        logic        cw;
    } exp_t;

    // upper/lower square, digit, expected pos, dir_valid, dir_cw
    typedef struct packed {
        logic       upper;
        logic [1:0] k;
        logic [2:0] pos;
        logic       dv;
        logic       cw;
    } sqv_t;

    sqv_t vecs [0:19] = '{
        '{1'b1, 2'd0, 3'd0, 1'b0, 1'b0},
        '{1'b1, 2'd1, 3'd1, 1'b1, 1'b1},
        '{1'b1, 2'd2, 3'd2, 1'b1, 1'b1},
        '{1'b1, 2'd3, 3'd3, 1'b1, 1'b1},
        '{1'b0, 2'd3, 3'd4, 1'b1, 1'b1},
        '{1'b0, 2'd2, 3'd5, 1'b1, 1'b1},
        '{1'b0, 2'd1, 3'd6, 1'b1, 1'b1},
        '{1'b0, 2'd0, 3'd7, 1'b1, 1'b1},
        '{1'b1, 2'd0, 3'd0, 1'b1, 1'b1},
        '{1'b0, 2'd0, 3'd7, 1'b1, 1'b0},
        '{1'b0, 2'd1, 3'd6, 1'b1, 1'b0},
        '{1'b0, 2'd2, 3'd5, 1'b1, 1'b0},
        '{1'b0, 2'd3, 3'd4, 1'b1, 1'b0},
        '{1'b1, 2'd3, 3'd3, 1'b1, 1'b0},
        '{1'b1, 2'd2, 3'd2, 1'b1, 1'b0},
        '{1'b1, 2'd1, 3'd1, 1'b1, 1'b0},
        '{1'b1, 2'd0, 3'd0, 1'b1, 1'b0},
        '{1'b1, 2'd1, 3'd1, 1'b1, 1'b1},
        '{1'b1, 2'd1, 3'd1, 1'b1, 1'b1},
        '{1'b0, 2'd3, 3'd4, 1'b0, 1'b0}
    };

    exp_t q[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_err_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] hex, input logic [3:0] hv, input logic sqv,
                                input logic [2:0] pos, input logic dv, input logic cw);
        exp_t e;
        e.hex = hex; e.hv = hv; e.sqv = sqv; e.pos = pos; e.dv = dv; e.cw = cw;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (scan_err_o) n_err_pulses++;
            if (frame_stb_o) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL frame_stb: got unexpected pulse, required none");
                end else begin
                    cur = q.pop_front();
                    check("frame_hex", 32'(digit_hex_o), 32'(cur.hex));
                    check("frame_hex_valid", 32'(hex_valid_o), 32'(cur.hv));
                    check("frame_valid", 32'(frame_valid_o), 32'd1);
                    @(negedge clk);
                    check("sq_valid", 32'(sq_valid_o), 32'(cur.sqv));
                    if (cur.sqv) check("sq_pos", 32'(sq_pos_o), 32'(cur.pos));
                    check("dir_valid", 32'(dir_valid_o), 32'(cur.dv));
                    if (cur.dv) check("dir_cw", 32'(dir_cw_o), 32'(cur.cw));
                end
            end
        end
    end

    task automatic idle_lines(input int n);
        an_in  = 4'hF;
        seg_in = 8'hFF;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_digit(input int k, input logic [7:0] g, input int dwell);
        logic [3:0] a;
        a      = 4'b0001;
        a      = a << k;
        an_in  = ~a;
        seg_in = ~g;
        repeat (dwell) @(negedge clk);
        idle_lines(2);
    endtask

    task automatic scan_frame(input logic [7:0] g0, g1, g2, g3, input int dwell);
        drive_digit(0, g0, dwell);
        drive_digit(1, g1, dwell);
        drive_digit(2, g2, dwell);
        drive_digit(3, g3, dwell);
    endtask

    task automatic sq_frame(input sqv_t v);
        logic [7:0] g [0:3];
        for (int i = 0; i < 4; i++) g[i] = 8'h00;
        g[v.k] = v.upper ? 8'h63 : 8'h5C;
        q.push_back(mk(16'h0000, 4'h0, 1'b1, v.pos, v.dv, v.cw));
        scan_frame(g[0], g[1], g[2], g[3], SQ_DW);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_digit_seg"}, digit_seg_o, 32'h0);
        check({tag, "_hex"}, 32'(digit_hex_o), 32'h0);
        check({tag, "_flags"},
              32'({hex_valid_o, frame_valid_o, frame_stb_o, sq_pos_o, sq_valid_o,
                   dir_cw_o, dir_valid_o, scan_err_o}), 32'h0);
    endtask

    initial begin
        // 1: reset with idle lines
        rst_n = 1'b0;
        idle_lines(5);
        check_all_zero("in_reset");
        rst_n = 1'b1;
        idle_lines(30);
        check_all_zero("after_reset");
        check("no_err_pulse_idle", 32'(n_err_pulses), 32'd0);

        // 2: "1234" with long dwell
        q.push_back(mk(16'h4321, 4'hF, 1'b0, 3'd0, 1'b0, 1'b0));
        scan_frame(8'h06, 8'h5B, 8'h4F, 8'h66, 1000);
        idle_lines(10);
        check("frame2_digit_seg", digit_seg_o, 32'h664F5B06);

        // 3: one-cycle glitch, then illegal anode pattern
        an_in  = 4'b1110;
        seg_in = ~8'h7F;
        @(negedge clk);
        idle_lines(50);
        check("glitch_no_capture", digit_seg_o, 32'h664F5B06);
        an_in = 4'b1100;
        repeat (20) @(negedge clk);
        idle_lines(10);
        check("scan_err_once", 32'(n_err_pulses), 32'd1);

        // 4 and 5: rotating square, reverse, hold, jump
        for (int i = 0; i < 20; i++) sq_frame(vecs[i]);
        q.push_back(mk(16'h0000, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0));
        scan_frame(8'h63, 8'h63, 8'h00, 8'h00, SQ_DW);
        idle_lines(10);

        // 6: timeout after a full frame
        q.push_back(mk(16'h4321, 4'hF, 1'b0, 3'd0, 1'b0, 1'b0));
        scan_frame(8'h06, 8'h5B, 8'h4F, 8'h66, SQ_DW);
        idle_lines(10);
        check("pre_timeout_frame_valid", 32'(frame_valid_o), 32'd1);
        check("pre_timeout_hex_valid", 32'(hex_valid_o), 32'hF);
        idle_lines(FTO + 100);
        check("timeout_frame_valid", 32'(frame_valid_o), 32'd0);
        check("timeout_hex_valid", 32'(hex_valid_o), 32'h0);
        check("timeout_sq_dir_valid", 32'({sq_valid_o, dir_valid_o}), 32'h0);
        check("timeout_fsm_idle", 32'(dut.state == IDLE), 32'd1);
        check("timeout_digit_seg_held", digit_seg_o, 32'h664F5B06);

        // reset mid-frame is asynchronous
        drive_digit(0, 8'h06, SQ_DW);
        drive_digit(1, 8'h5B, SQ_DW);
        an_in  = 4'b1011;
        seg_in = ~8'h4F;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        idle_lines(3);
        rst_n = 1'b1;
        idle_lines(10);

        // first square after reset is not a direction reference
        sq_frame('{1'b1, 2'd0, 3'd0, 1'b0, 1'b0});
        sq_frame('{1'b1, 2'd1, 3'd1, 1'b1, 1'b1});
        idle_lines(10);

        check("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
